mem_stream_reader: RTL and testbench

MEM_STREAM_READER -- requirements
Module: mem_stream_reader

---
 rtl/mem_stream_reader.sv | 133 +++++++++++++
 tb/tb_mem_stream_reader.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stream_reader.sv
// mem_stream_reader
// Reads a burst of consecutive words from a single-port BRAM (one-cycle read
// latency) and streams them out over a valid/ready interface. A 2-entry FIFO
// absorbs the read latency so the stream sustains one word per cycle, and
// reads stall under backpressure.
//
// Ports
//   clock, reset_n            single clock, async active-low reset
//   start                     one-cycle burst request (ignored while busy/done)
//   base_address, length      burst parameters, sampled with start
//   busy, done                burst in progress / one-cycle completion pulse
//   ram_enable, write_enable  BRAM control (write_enable tied low)
//   address                   BRAM read address
//   output_data               BRAM read data, valid the cycle after ram_enable
//   out_data, out_valid       streamed word and its valid flag
//   out_ready                 consumer accept
//
// state | meaning
// IDLE  | waiting for start, no reads, stream empty
// READ  | issuing reads, bounded to two words outstanding
// DRAIN | all reads issued, waiting for the final handshake
module mem_stream_reader #(
  parameter int RAM_WIDTH     = 32,
  parameter int RAM_ADDR_BITS = 9
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     start,
  input  logic [RAM_ADDR_BITS-1:0] base_address,
  input  logic [RAM_ADDR_BITS:0]   length,
  output logic                     busy,
  output logic                     done,
  output logic                     ram_enable,
  output logic                     write_enable,
  output logic [RAM_ADDR_BITS-1:0] address,
  input  logic [RAM_WIDTH-1:0]     output_data,
  output logic [RAM_WIDTH-1:0]     out_data,
  output logic                     out_valid,
  input  logic                     out_ready
);

  typedef enum logic [1:0] {IDLE, READ, DRAIN} state_t;

  localparam logic [RAM_ADDR_BITS-1:0] ADDR_ONE = 1;
  localparam logic [RAM_ADDR_BITS:0]   CNT_ONE  = 1;
  localparam logic [RAM_ADDR_BITS:0]   CNT_ZERO = 0;

  state_t                   state;
  logic [RAM_ADDR_BITS:0]   reads_left;
  logic [RAM_ADDR_BITS:0]   words_left;
  logic                     in_flight;
  logic [RAM_WIDTH-1:0]     fifo_mem [2];
  logic                     wr_ptr;
  logic                     rd_ptr;
  logic [1:0]               fifo_count;
  logic [1:0]               outstanding;
  logic                     pop;

  assign write_enable = 1'b0;
  assign busy         = (state != IDLE);
  assign out_valid    = (fifo_count != 2'd0);
  assign out_data     = fifo_mem[rd_ptr];
  assign pop          = out_valid && out_ready;

  // Words issued but not yet handed off: buffered plus the one in the BRAM
  // pipeline. Capping this at two keeps the FIFO from ever overflowing; a pop
  // in the same cycle frees a slot, which is what lets the stream run at
  // full rate.
  assign outstanding = fifo_count + {1'b0, in_flight};
  assign ram_enable  = (state == READ) &&
                       ((outstanding < 2'd2) || ((outstanding == 2'd2) && pop));

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      reads_left  <= CNT_ZERO;
      words_left  <= CNT_ZERO;
      address     <= '0;
      done        <= 1'b0;
      in_flight   <= 1'b0;
      wr_ptr      <= 1'b0;
      rd_ptr      <= 1'b0;
      fifo_count  <= 2'd0;
      fifo_mem[0] <= '0;
      fifo_mem[1] <= '0;
    end else begin
      done      <= 1'b0;
      in_flight <= ram_enable;

      if (in_flight) begin
        fifo_mem[wr_ptr] <= output_data;
        wr_ptr           <= ~wr_ptr;
      end
      if (pop) begin
        rd_ptr     <= ~rd_ptr;
        words_left <= words_left - CNT_ONE;
      end
      fifo_count <= fifo_count + {1'b0, in_flight} - {1'b0, pop};

      if (ram_enable) begin
        address    <= address + ADDR_ONE;
        reads_left <= reads_left - CNT_ONE;
      end

      case (state)
        IDLE: begin
          // A start landing on the done cycle belongs to the finished burst.
          if (start && !done) begin
            if (length == CNT_ZERO) begin
              done <= 1'b1;
            end else begin
              state      <= READ;
              address    <= base_address;
              reads_left <= length;
              words_left <= length;
            end
          end
        end
        READ: begin
          if (ram_enable && (reads_left == CNT_ONE)) state <= DRAIN;
        end
        DRAIN: begin
          if (pop && (words_left == CNT_ONE)) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stream_reader.sv
module tb_mem_stream_reader;
  localparam int W     = 32;
  localparam int AB    = 9;
  localparam int DEPTH = 512;

  logic          clock = 1'b0;
  logic          reset_n = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] base_address = '0;
  logic [AB:0]   length = '0;
  logic          busy, done, ram_enable, write_enable, out_valid;
  logic [AB-1:0] address;
  logic [W-1:0]  output_data = '0;
  logic [W-1:0]  out_data;
  logic          out_ready = 1'b0;

  mem_stream_reader #(.RAM_WIDTH(W), .RAM_ADDR_BITS(AB)) dut (
    .clock(clock), .reset_n(reset_n), .start(start),
    .base_address(base_address), .length(length),
    .busy(busy), .done(done), .ram_enable(ram_enable),
    .write_enable(write_enable), .address(address),
    .output_data(output_data), .out_data(out_data),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  always #5 clock = ~clock;

  // BRAM image: word[a] = a, one-cycle read latency
  always @(posedge clock) if (ram_enable) output_data <= W'(address);

  int checks = 0;
  int failures = 0;

  // observations of the last burst
  logic [W-1:0]  got_q[$];
  logic [AB-1:0] addr_q[$];
  logic [W-1:0]  exp_q[$];
  int first_valid_k, done_k, en_cnt, max_out, stab_err, busy_cnt, we_seen;
  logic busy_k0, busy_at_done;

  // reference: the burst is simply base, base+1, ... modulo the memory depth
  task automatic model(input logic [AB-1:0] b, input logic [AB:0] n);
    exp_q.delete();
    for (int i = 0; i < int'(n); i++) exp_q.push_back(W'((int'(b) + i) % DEPTH));
  endtask

  // Runs one burst and records what happened; no judging here.
  // k = number of rising edges since the start edge at the sampling negedge.
  task automatic run_burst(input logic [AB-1:0] b, input logic [AB:0] n,
                           input int mode, input int budget, input int inj_k,
                           input logic [AB-1:0] inj_b, input logic [AB:0] inj_n);
    int outst;
    logic pv, pr;
    logic [W-1:0] pd;
    got_q.delete(); addr_q.delete();
    first_valid_k = -1; done_k = -1; en_cnt = 0; max_out = 0; stab_err = 0;
    busy_cnt = 0; we_seen = 0; busy_k0 = 1'b0; busy_at_done = 1'b1;
    outst = 0; pv = 1'b0; pr = 1'b0; pd = '0;
    start = 1'b1; base_address = b; length = n;
    @(posedge clock); #1;
    start = 1'b0;
    for (int k = 0; k < budget; k++) begin
      case (mode)
        0: out_ready = 1'b1;
        1: out_ready = ((k % 4) == 0) || ((k % 4) == 3);
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      if (k == inj_k) begin start = 1'b1; base_address = inj_b; length = inj_n; end
      @(negedge clock);
      if (k == 0) busy_k0 = busy;
      if (busy) busy_cnt++;
      if (write_enable !== 1'b0) we_seen++;
      if (pv && !pr && (!out_valid || out_data !== pd)) stab_err++;
      if (out_valid && first_valid_k < 0) first_valid_k = k;
      if (ram_enable) begin en_cnt++; addr_q.push_back(address); end
      if (out_valid && out_ready) got_q.push_back(out_data);
      outst = outst + (ram_enable ? 1 : 0) - ((out_valid && out_ready) ? 1 : 0);
      if (outst > max_out) max_out = outst;
      pv = out_valid; pr = out_ready; pd = out_data;
      if (done) begin done_k = k; busy_at_done = busy; end
      @(posedge clock); #1;
      start = 1'b0;
      if (done_k >= 0) break;
    end
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    #23;
    checks++;
    if ({busy, done, ram_enable, write_enable, out_valid} !== 5'b0 ||
        address !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL reset_outputs ctl=%b addr=%0d data=%0d expected all zero",
               {busy, done, ram_enable, write_enable, out_valid}, address, out_data);
    end
    @(posedge clock); #1;
    reset_n = 1'b1;
  endtask

  task automatic test_basic();
    int bad = 0;
    run_burst(9'd0, 10'd32, 0, 100, -1, '0, '0);
    model(9'd0, 10'd32);
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (got_q.size() != 32 || bad != 0) begin
      failures++; $display("FAIL basic_data words=%0d bad=%0d expected 32 words bad=0", got_q.size(), bad);
    end
    bad = 0;
    foreach (exp_q[i]) if (i < addr_q.size() && addr_q[i] !== exp_q[i][AB-1:0]) bad++;
    checks++;
    if (en_cnt != 32 || bad != 0) begin
      failures++; $display("FAIL basic_reads enables=%0d badaddr=%0d expected 32 and 0", en_cnt, bad);
    end
    checks++;
    if (first_valid_k != 2) begin
      failures++; $display("FAIL basic_latency first_valid=%0d expected 2", first_valid_k);
    end
    checks++;
    if (done_k != 34) begin
      failures++; $display("FAIL basic_done done_at=%0d expected 34", done_k);
    end
    checks++;
    if (busy_k0 !== 1'b1 || busy_at_done !== 1'b0 || we_seen != 0) begin
      failures++; $display("FAIL basic_busy busy0=%b busy_done=%b we=%0d expected 1 0 0", busy_k0, busy_at_done, we_seen);
    end
  endtask

  task automatic test_wrap();
    int bad = 0;
    run_burst(9'd510, 10'd4, 0, 40, -1, '0, '0);
    model(9'd510, 10'd4);
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
    foreach (exp_q[i]) if (i < addr_q.size() && addr_q[i] !== exp_q[i][AB-1:0]) bad++;
    checks++;
    if (got_q.size() != 4 || addr_q.size() != 4 || bad != 0 || done_k != 6) begin
      failures++; $display("FAIL wrap words=%0d reads=%0d bad=%0d done_at=%0d expected 4 4 0 6",
                           got_q.size(), addr_q.size(), bad, done_k);
    end
  endtask

  task automatic test_backpressure();
    int bad = 0;
    run_burst(9'd0, 10'd8, 1, 200, -1, '0, '0);
    model(9'd0, 10'd8);
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (got_q.size() != 8 || bad != 0 || done_k < 0) begin
      failures++; $display("FAIL bp_data words=%0d bad=%0d done_at=%0d expected 8 0 >=0", got_q.size(), bad, done_k);
    end
    checks++;
    if (stab_err != 0 || max_out > 2 || en_cnt != 8) begin
      failures++; $display("FAIL bp_flow unstable=%0d max_outstanding=%0d enables=%0d expected 0 <=2 8",
                           stab_err, max_out, en_cnt);
    end
  endtask

  task automatic test_zero_len();
    run_burst(9'd77, 10'd0, 0, 10, -1, '0, '0);
    checks++;
    if (done_k != 0 || en_cnt != 0 || busy_cnt != 0 || got_q.size() != 0) begin
      failures++; $display("FAIL zero_len done_at=%0d enables=%0d busy_cycles=%0d words=%0d expected 0 0 0 0",
                           done_k, en_cnt, busy_cnt, got_q.size());
    end
  endtask

  task automatic test_start_while_busy();
    int bad = 0;
    int late_en = 0;
    run_burst(9'd100, 10'd12, 0, 100, 5, 9'd300, 10'd3);
    model(9'd100, 10'd12);
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (ram_enable || busy) late_en++;
      @(posedge clock); #1;
    end
    checks++;
    if (got_q.size() != 12 || bad != 0 || en_cnt != 12 || done_k != 14 || late_en != 0) begin
      failures++; $display("FAIL start_busy words=%0d bad=%0d enables=%0d done_at=%0d after=%0d expected 12 0 12 14 0",
                           got_q.size(), bad, en_cnt, done_k, late_en);
    end
  endtask

  task automatic test_start_at_done();
    int late = 0;
    int bad = 0;
    run_burst(9'd20, 10'd3, 0, 40, 5, 9'd40, 10'd4);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      if (ram_enable || busy || done) late++;
      @(posedge clock); #1;
    end
    checks++;
    if (done_k != 5 || late != 0) begin
      failures++; $display("FAIL start_at_done done_at=%0d activity_after=%0d expected 5 0", done_k, late);
    end
    run_burst(9'd40, 10'd4, 0, 40, -1, '0, '0);
    model(9'd40, 10'd4);
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (got_q.size() != 4 || bad != 0 || done_k != 6) begin
      failures++; $display("FAIL after_done_burst words=%0d bad=%0d done_at=%0d expected 4 0 6", got_q.size(), bad, done_k);
    end
  endtask

  task automatic test_reset_abort();
    int spurious = 0;
    int bad = 0;
    run_burst(9'd0, 10'd32, 0, 10, -1, '0, '0);
    checks++;
    if (done_k != -1 || busy !== 1'b1) begin
      failures++; $display("FAIL abort_pre done_at=%0d busy=%b expected -1 1", done_k, busy);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, ram_enable, write_enable, out_valid} !== 5'b0 ||
        address !== '0 || out_data !== '0) begin
      failures++;
      $display("FAIL abort_outputs ctl=%b addr=%0d data=%0d expected all zero",
               {busy, done, ram_enable, write_enable, out_valid}, address, out_data);
    end
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      if (done || out_valid || ram_enable) spurious++;
      @(posedge clock); #1;
    end
    reset_n = 1'b1;
    run_burst(9'd5, 10'd2, 0, 20, -1, '0, '0);
    model(9'd5, 10'd2);
    foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
    checks++;
    if (spurious != 0 || got_q.size() != 2 || bad != 0 || done_k != 4 || first_valid_k != 2) begin
      failures++; $display("FAIL abort_restart spurious=%0d words=%0d bad=%0d done_at=%0d first=%0d expected 0 2 0 4 2",
                           spurious, got_q.size(), bad, done_k, first_valid_k);
    end
  endtask

  task automatic test_random();
    for (int t = 0; t < 10; t++) begin
      logic [AB-1:0] b;
      logic [AB:0] n;
      int mode;
      int bad;
      b = AB'($urandom_range(0, DEPTH - 1));
      n = (AB+1)'($urandom_range(0, 24));
      mode = $urandom_range(0, 2);
      bad = 0;
      run_burst(b, n, mode, 40 * int'(n) + 50, -1, '0, '0);
      model(b, n);
      foreach (exp_q[i]) if (i < got_q.size() && got_q[i] !== exp_q[i]) bad++;
      foreach (exp_q[i]) if (i < addr_q.size() && addr_q[i] !== exp_q[i][AB-1:0]) bad++;
      checks++;
      if (got_q.size() != int'(n) || addr_q.size() != int'(n) || bad != 0 || done_k < 0) begin
        failures++; $display("FAIL rand_burst base=%0d len=%0d words=%0d reads=%0d bad=%0d done_at=%0d",
                             b, n, got_q.size(), addr_q.size(), bad, done_k);
      end
      checks++;
      if (stab_err != 0 || max_out > 2 || (mode == 0 && done_k != int'(n) + 2)) begin
        failures++; $display("FAIL rand_flow len=%0d mode=%0d unstable=%0d max_outstanding=%0d done_at=%0d",
                             n, mode, stab_err, max_out, done_k);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_wrap();
    test_backpressure();
    test_zero_len();
    test_start_while_busy();
    test_start_at_done();
    test_reset_abort();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
